// File: rtl/tom_pit.sv
// Programmable interval timer: prescaler chained into a divider, both
// down-counting with auto reload, driving a one-cycle tick and a sticky irq.
module tom_pit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             pre_wr,
  input  logic             div_wr,
  input  logic             en,
  input  logic             ack,
  output logic [WIDTH-1:0] pre_q,
  output logic [WIDTH-1:0] div_q,
  output logic             tick,
  output logic             irq
);

  logic [WIDTH-1:0] pre_rld_q, pre_rld_d;
  logic [WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] div_rld_q, div_rld_d;
  logic [WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic             irq_q, irq_d;
  logic             pre_wrap;
  logic             div_wrap;

  // Next-state: a write to a counter always beats its own terminal-count reload.
  always_comb begin
    pre_rld_d = pre_rld_q;
    pre_cnt_d = pre_cnt_q;
    div_rld_d = div_rld_q;
    div_cnt_d = div_cnt_q;
    irq_d     = irq_q;
    pre_wrap  = 1'b0;
    div_wrap  = 1'b0;

    if (pre_wr) begin
      pre_rld_d = din;
      pre_cnt_d = din;
    end else if (en) begin
      if (pre_cnt_q == '0) begin
        pre_cnt_d = pre_rld_q;
        pre_wrap  = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q - WIDTH'(1);
      end
    end

    if (div_wr) begin
      div_rld_d = din;
      div_cnt_d = din;
    end else if (pre_wrap) begin
      if (div_cnt_q == '0) begin
        div_cnt_d = div_rld_q;
        div_wrap  = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q - WIDTH'(1);
      end
    end

    tick_d = div_wrap;

    // A wrap in the same cycle as ack keeps the interrupt pending.
    if (div_wrap) begin
      irq_d = 1'b1;
    end else if (ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pre_rld_q <= '0;
      pre_cnt_q <= '0;
      div_rld_q <= '0;
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      pre_rld_q <= pre_rld_d;
      pre_cnt_q <= pre_cnt_d;
      div_rld_q <= div_rld_d;
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      irq_q     <= irq_d;
    end
  end

  assign pre_q = pre_cnt_q;
  assign div_q = div_cnt_q;
  assign tick  = tick_q;
  assign irq   = irq_q;

endmodule
